// File: rtl/muldiv_if.sv
// Control-unit handshake for the MULT/DIV sequencer: request side in, Hi/Lo results and status out.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             load_hi;
  logic             load_lo;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_zero;

  modport master (output start, op, op_a, op_b, abort,
                  input  busy, done, load_hi, load_lo, hi_out, lo_out, div_zero);
  modport slave  (input  start, op, op_a, op_b, abort,
                  output busy, done, load_hi, load_lo, hi_out, lo_out, div_zero);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative signed MULT (shift-add) / DIV (restoring) sequencer, WIDTH steps per operation.
// Optional MULDIV_EARLY_OUT_EN commits zero results straight from CHECK when an operand is 0.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic               dz_nxt, early_nxt;
  logic               is_div, neg_a, neg_b;
  logic [WIDTH-1:0]   a_r, b_r, m_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_up, div_trial;
  logic [2*WIDTH:0]   div_sh;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign mag_a = a_r[WIDTH-1] ? -a_r : a_r;
  assign mag_b = b_r[WIDTH-1] ? -b_r : b_r;

  // Right-shifting product register: the carry out of the add becomes the new MSB.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_r} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Partial remainder needs WIDTH+1 bits after the shift since |divisor| may be 2^(WIDTH-1).
  assign div_sh    = {acc, 1'b0};
  assign div_up    = div_sh[2*WIDTH:WIDTH];
  assign div_trial = div_up - {1'b0, m_r};
  assign div_step  = div_trial[WIDTH] ? div_sh[2*WIDTH-1:0]
                                      : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dz_nxt    = 1'b0;
    early_nxt = 1'b0;
    case (state)
      IDLE:  if (bus.start && (bus.op == OP_MULT || bus.op == OP_DIV)) state_nxt = CHECK;
      CHECK: begin
        if (is_div && b_r == '0) begin
          state_nxt = IDLE;
          dz_nxt    = 1'b1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if ((!is_div && (a_r == '0 || b_r == '0)) || (is_div && a_r == '0)) begin
          state_nxt = IDLE;
          early_nxt = 1'b1;
        end
`endif
        else state_nxt = RUN;
      end
      RUN:   if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
      dz_nxt    = 1'b0;
      early_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div       <= 1'b0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      m_r          <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.load_hi  <= 1'b0;
      bus.load_lo  <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi_out   <= '0;
      bus.lo_out   <= '0;
    end else begin
      bus.busy     <= (state_nxt != IDLE);
      bus.div_zero <= dz_nxt;
      bus.done     <= 1'b0;
      bus.load_hi  <= 1'b0;
      bus.load_lo  <= 1'b0;
      case (state)
        IDLE: if (state_nxt == CHECK) begin
          a_r    <= bus.op_a;
          b_r    <= bus.op_b;
          is_div <= (bus.op == OP_DIV);
        end
        CHECK: begin
          neg_a <= a_r[WIDTH-1];
          neg_b <= b_r[WIDTH-1];
          m_r   <= is_div ? mag_b : mag_a;
          acc   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          cnt   <= '0;
          if (early_nxt) begin
            bus.hi_out  <= '0;
            bus.lo_out  <= '0;
            bus.done    <= 1'b1;
            bus.load_hi <= 1'b1;
            bus.load_lo <= 1'b1;
          end
        end
        RUN: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!bus.abort) begin
          bus.hi_out  <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          bus.lo_out  <= is_div ? quo : prod[WIDTH-1:0];
          bus.done    <= 1'b1;
          bus.load_hi <= 1'b1;
          bus.load_lo <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + randomized bench for muldiv_seq against a plain-arithmetic signed MULT/DIV model.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Full transaction: issue start, wait for done/div_zero, compare with the model.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int intrude);
    longint la, lb;
    logic [63:0] p, q, r;
    logic [31:0] eh, el;
    bit dz, early, seen;
    int lat, k, busy_cnt;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    dz = (o == 2'b10) && (b == 0);
    early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    early = (o == 2'b01 && (a == 0 || b == 0)) || (o == 2'b10 && a == 0 && b != 0);
`endif
    if (o == 2'b01) begin
      p = la * lb;
      eh = p[63:32]; el = p[31:0];
    end else if (!dz) begin
      q = la / lb; r = la % lb;
      eh = r[31:0]; el = q[31:0];
    end else begin
      eh = mhi; el = mlo;
    end
    lat = (dz || early) ? 1 : 34;

    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    k = 0; busy_cnt = 1; seen = 0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      k++;
      bus.start = (k == intrude);
      if (k == intrude) begin
        bus.op = 2'b10; bus.op_a = $urandom; bus.op_b = 32'd3;
      end
      if (bus.done || bus.div_zero) seen = 1;
      else if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    chk("latency", k, lat);
    chk("busy_cycles", busy_cnt, lat);
    chk("busy_low_at_end", bus.busy, 0);
    chk("div_zero", bus.div_zero, dz);
    chk("done", bus.done, !dz);
    chk("load_hi", bus.load_hi, !dz);
    chk("load_lo", bus.load_lo, !dz);
    chk("hi", bus.hi_out, eh);
    chk("lo", bus.lo_out, el);
    mhi = eh; mlo = el;
    @(negedge clk);
    chk("done_pulse_end", {bus.done, bus.div_zero, bus.load_hi, bus.load_lo}, 0);
  endtask

  // Start an op, then either abort or pull reset at cycle 'at' after the start edge.
  task automatic do_cancel(input logic [31:0] a, input logic [31:0] b, input int at,
                           input bit use_reset);
    bit any_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < at; i++) @(negedge clk);
    if (use_reset) begin
      reset = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_flags", {bus.done, bus.load_hi, bus.load_lo, bus.div_zero}, 0);
      chk("rst_hi", bus.hi_out, 0);
      chk("rst_lo", bus.lo_out, 0);
      mhi = '0; mlo = '0;
      @(negedge clk);
      reset = 1'b1;
    end else begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
    end
    any_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.load_hi || bus.load_lo) any_done = 1;
    end
    chk("cancel_no_done", any_done, 0);
    chk("cancel_hi", bus.hi_out, mhi);
    chk("cancel_lo", bus.lo_out, mlo);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_flags", {bus.done, bus.load_hi, bus.load_lo, bus.div_zero}, 0);
    chk("reset_hilo", {bus.hi_out, bus.lo_out}, 0);
    reset = 1'b1;

    // Reserved/none opcodes must not start anything; abort in IDLE is harmless.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.abort = 1'b1;
    @(negedge clk);
    bus.op = 2'b11;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("ignored_op_busy", bus.busy, 0);
    @(negedge clk);
    chk("ignored_op_done", bus.done, 0);

    do_op(2'b01, 32'd7, 32'hFFFF_FFFD, 5);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b01, 32'h1234_5678, 32'h1, 0);
    do_op(2'b10, 32'd5, 32'd0, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(2'b01, 32'd0, 32'd5, 0);
    do_op(2'b10, 32'd0, 32'd9, 0);

    do_cancel(32'd1234, 32'd5678, 10, 1'b0);
    do_cancel(32'hDEAD_BEEF, 32'h1234_5678, 20, 1'b1);

    for (int n = 0; n < 24; n++)
      do_op($urandom_range(0, 1) ? 2'b01 : 2'b10, pick(), pick(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the signed MULT/DIV resource of the multicycle CPU. The control unit issues a single-cycle start with an operation code and the A/B register operands. The block runs an iterative 32-step shift-add multiply or restoring divide, then presents the Hi/Lo results with load strobes. It also flags division by zero to the exception path, and reports busy so the control unit can stall dependent MFHI/MFLO.

## Interface

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; forces IDLE and clears all outputs
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 none, 01 signed MULT, 10 signed DIV, 11 reserved
- op_a  input  WIDTH  multiplicand / dividend (A register)
- op_b  input  WIDTH  multiplier / divisor (B register)
- abort  input  1  exception flush; cancels any operation in flight
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when a result is committed
- load_hi  output  1  one-cycle Hi write strobe, coincident with done
- load_lo  output  1  one-cycle Lo write strobe, coincident with done
- hi_out  output  WIDTH  MULT upper product / DIV remainder
- lo_out  output  WIDTH  MULT lower product / DIV quotient
- div_zero  output  1  one-cycle pulse on DIV with op_b == 0

## Operation

- States: IDLE, CHECK, RUN, FIX.
- IDLE:
  - start=1 with op ∈ {01,10} latches op_a, op_b and op, then moves to CHECK.
  - start with op 00/11 is ignored.
  - start in any other state is ignored.
- CHECK:
  - Records the operand signs and converts both operands to magnitudes.
  - Clears the step counter.
  - For DIV with divisor 0: pulses div_zero, returns to IDLE, no done, hi_out/lo_out unchanged.
  - Otherwise moves to RUN.
- RUN:
  - One iteration per cycle on a 2·WIDTH accumulator: shift-add for MULT, shift-subtract-restore for DIV.
  - The counter runs 0..WIDTH-1. FIX is entered on the edge where the counter equals WIDTH-1.
- FIX:
  - Applies sign correction and commits hi_out/lo_out.
  - Pulses done, load_hi and load_lo; returns to IDLE.
- Arithmetic:
  - MULT: {hi,lo} = 64-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No exception is raised.
- abort:
  - Has priority over every transition except reset.
  - At the next edge the block goes to IDLE with no done and no strobes; hi_out/lo_out are unchanged.
  - abort in IDLE has no effect.
- Reset:
  - Asynchronous; valid mid-operation.
  - busy, done, load_hi, load_lo, div_zero = 0; hi_out = lo_out = 0; state IDLE.

## Timing

- Edge 0 is the edge that samples start. Edge 1 leaves CHECK. Edges 2..33 are RUN iterations. Edge 34 is FIX→IDLE.
- done, load_hi, load_lo are high in the cycle after edge 34. hi_out/lo_out carry the new value in that same cycle.
- busy is high from after edge 0 until edge 34.
- div_zero is high in the cycle after edge 1; busy drops at edge 1.
- The earliest next start is sampled at edge 35 (or at edge 2 after a div_zero).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- MULDIV_EARLY_OUT_EN:
  - Defined: in CHECK, MULT with op_a or op_b equal to 0 commits hi = lo = 0. DIV with op_a = 0 and op_b ≠ 0 also commits hi = lo = 0. In both cases done/load_hi/load_lo pulse in the cycle after edge 1 and RUN is skipped.
  - Undefined: fixed latency of 34 edges for every non-div-zero operation.

## Test plan

- MULT op_a=7, op_b=0xFFFFFFFD -> done after edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 34 cycles.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; load_hi/load_lo coincide with done.
- DIV op_a=5, op_b=0 -> div_zero pulse after edge 1; no done; hi/lo hold their previous values (e.g. 0x12345678/0x9ABCDEF0).
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no div_zero.
- Second start issued at cycle 5 is ignored. A following run with abort at cycle 10 gives IDLE at the next edge, no done, outputs unchanged. A further run with reset low at cycle 20 gives all outputs 0 immediately.
- With MULDIV_EARLY_OUT_EN: MULT 0 × 5 -> done after edge 1, hi=lo=0. Without the macro: the same stimulus completes after edge 34.
